// File: rtl/synth_mem_pkg.sv
// rtl/synth_mem_pkg.sv - shared widths, requester ids and FSM states for patch_mem_arbiter
package synth_mem_pkg;
  localparam int BANK_W = 3;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int N_REQ  = 3;

  localparam logic [1:0] REQ_SYX_LD   = 2'd0;
  localparam logic [1:0] REQ_SYX_DUMP = 2'd1;
  localparam logic [1:0] REQ_HOST     = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

  // Successor of a requester id in round-robin order (2 wraps to 0).
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == REQ_HOST) ? REQ_SYX_LD : id + 2'd1;
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - three-way round-robin grant with registered search pointer
module rr_arbiter3
  import synth_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] eligible,
  input  logic             grant_en,
  output logic             grant_valid,
  output logic [1:0]       grant_id
);
  logic [1:0] ptr;
  logic [1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr;
    cand        = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
      cand = next_id(cand);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_SYX_LD;
    end else if (grant_en) begin
      ptr <= next_id(grant_id);
    end
  end
endmodule

// File: rtl/patch_mem_arbiter.sv
// rtl/patch_mem_arbiter.sv - round-robin arbiter sharing the synth parameter register file
module patch_mem_arbiter
  import synth_mem_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int ADDR_LIMIT = 64
) (
  input  logic                    sys_clk,
  input  logic                    reset_reg_N,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*BANK_W-1:0] req_bank,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  input  logic                    bulk_lock,
  output logic [N_REQ-1:0]        ack,
  output logic                    ack_err,
  output logic [DATA_W-1:0]       rdata,
  output logic [BANK_W-1:0]       mem_bank,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [DATA_W-1:0]       mem_rdata
);
  state_t             state, state_nxt;
  logic [1:0]         gid_q;
  logic               we_q;
  logic [BANK_W-1:0]  bank_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [2:0]         cnt_q;
  logic [N_REQ-1:0]   eligible;
  logic               grant_valid;
  logic [1:0]         grant_id;
  logic               grant_en;
  logic               addr_bad;

  // The host port is held off during sysex bulk transfers; in-flight host work is unaffected.
  always_comb begin
    eligible               = '0;
    eligible[REQ_SYX_LD]   = req[REQ_SYX_LD];
    eligible[REQ_SYX_DUMP] = req[REQ_SYX_DUMP];
    eligible[REQ_HOST]     = req[REQ_HOST] & ~bulk_lock;
  end

  assign addr_bad = int'(addr_q) >= ADDR_LIMIT;

  rr_arbiter3 u_rr (
    .clk         (sys_clk),
    .rst_n       (reset_reg_N),
    .eligible    (eligible),
    .grant_en    (grant_en),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          grant_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (addr_bad) begin
          state_nxt = ACK;
        end else if (we_q) begin
          mem_we    = 1'b1;
          state_nxt = ACK;
        end else begin
          mem_re    = 1'b1;
          state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt_q == 3'd1) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state   <= IDLE;
      gid_q   <= '0;
      we_q    <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            gid_q   <= grant_id;
            we_q    <= req_we[grant_id];
            bank_q  <= req_bank[BANK_W*int'(grant_id) +: BANK_W];
            addr_q  <= req_addr[ADDR_W*int'(grant_id) +: ADDR_W];
            wdata_q <= req_wdata[DATA_W*int'(grant_id) +: DATA_W];
          end
        end
        ISSUE: begin
          err_q <= addr_bad;
          cnt_q <= 3'(RD_LAT);
          if (addr_bad) rdata_q <= '0;
        end
        RDWAIT: begin
          if (cnt_q == 3'd1) rdata_q <= mem_rdata;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign ack       = (state == ACK) ? (N_REQ'(1) << gid_q) : '0;
  assign ack_err   = (state == ACK) & err_q;
  assign rdata     = rdata_q;
  assign mem_bank  = bank_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_patch_mem_arbiter.sv
// tb/tb_patch_mem_arbiter.sv - randomized self-checking bench for patch_mem_arbiter
module tb_patch_mem_arbiter;
  localparam int RD_LAT     = 2;
  localparam int ADDR_LIMIT = 64;

  logic        sys_clk = 1'b0;
  logic        reset_reg_N;
  logic [2:0]  req, req_we;
  logic [8:0]  req_bank;
  logic [20:0] req_addr;
  logic [23:0] req_wdata;
  logic        bulk_lock;
  logic [2:0]  ack;
  logic        ack_err;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [2:0]  mem_bank;
  logic [6:0]  mem_addr;
  logic        mem_we, mem_re;

  always #5 sys_clk = ~sys_clk;

  patch_mem_arbiter #(.RD_LAT(RD_LAT), .ADDR_LIMIT(ADDR_LIMIT)) dut (
    .sys_clk(sys_clk), .reset_reg_N(reset_reg_N), .req(req), .req_we(req_we),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
    .bulk_lock(bulk_lock), .ack(ack), .ack_err(ack_err), .rdata(rdata),
    .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_val(input int k);
    return 8'(k) ^ 8'h83;
  endfunction

  // Parameter memory with RD_LAT cycles from mem_re to valid mem_rdata.
  logic [7:0] mem_arr [0:1023];
  logic [7:0] pipe [0:RD_LAT-1];
  bit         mem_ready = 1'b0;
  assign mem_rdata = pipe[RD_LAT-1];

  always @(posedge sys_clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 1024; k++) mem_arr[k] <= init_val(k);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem_arr[{mem_bank, mem_addr}] <= mem_wdata;
    end
    pipe[0] <= mem_re ? mem_arr[{mem_bank, mem_addr}] : 8'h00;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end

  // Transaction-level reference state.
  logic [7:0] ref_mem [0:1023];
  logic [2:0] pending;
  int         mptr;
  logic       t_we    [0:2];
  logic [2:0] t_bank  [0:2];
  logic [6:0] t_addr  [0:2];
  logic [7:0] t_wdata [0:2];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [2:0] elig, input int p);
    for (int k = 0; k < 3; k++) if (elig[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic post(input int i, input logic we, input logic [2:0] b,
                      input logic [6:0] a, input logic [7:0] d);
    t_we[i] = we; t_bank[i] = b; t_addr[i] = a; t_wdata[i] = d;
    req_we[i] = we;
    req_bank[3*i +: 3]  = b;
    req_addr[7*i +: 7]  = a;
    req_wdata[8*i +: 8] = d;
    req[i] = 1'b1;
    pending[i] = 1'b1;
  endtask

  task automatic wait_ack(input string tag, output logic [2:0] a);
    a = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack != 3'b000) begin
        a = ack;
        return;
      end
    end
    check({tag, " ack_timeout"}, 32'(ack), 32'hFFFF_FFFF);
  endtask

  // Score one observed ack against the round-robin model; optionally drop that request.
  task automatic process_ack(input string tag, input logic [2:0] a, input bit drop);
    int id;
    int k;
    bit bad;
    id = rr_pick(pending & {~bulk_lock, 2'b11}, mptr);
    check({tag, " grant"}, 32'(a), (id < 0) ? 32'd0 : (32'd1 << id));
    if (id < 0) return;
    k   = int'({t_bank[id], t_addr[id]});
    bad = int'(t_addr[id]) >= ADDR_LIMIT;
    check({tag, " ack_err"}, 32'(ack_err), 32'(bad));
    if (bad) check({tag, " err_rdata"}, 32'(rdata), 32'd0);
    else if (t_we[id]) ref_mem[k] = t_wdata[id];
    else check({tag, " rdata"}, 32'(rdata), 32'(ref_mem[k]));
    mptr = (id + 1) % 3;
    if (drop) begin
      req[id] = 1'b0;
      pending[id] = 1'b0;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {ack, ack_err, rdata, mem_bank, mem_addr, mem_wdata, mem_we, mem_re};
  endfunction

  task automatic do_reset();
    reset_reg_N = 1'b0;
    req = '0; pending = '0; bulk_lock = 1'b0; mptr = 0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 32'd0);
    reset_reg_N = 1'b1;
    tick();
  endtask

  logic [2:0] a;

  initial begin
    req = '0; req_we = '0; req_bank = '0; req_addr = '0; req_wdata = '0;
    bulk_lock = 1'b0; pending = '0; mptr = 0; reset_reg_N = 1'b0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_val(k);
    do_reset();

    // Host write: strobe in cycle 1, ack in cycle 2.
    post(2, 1'b1, 3'd2, 7'h10, 8'hA5);
    tick();
    check("wr mem_we", 32'(mem_we), 32'd1);
    check("wr mem_re", 32'(mem_re), 32'd0);
    check("wr bus", {13'd0, mem_bank, mem_addr, mem_wdata}, {13'd0, 3'd2, 7'h10, 8'hA5});
    check("wr early_ack", 32'(ack), 32'd0);
    tick();
    check("wr ack", 32'(ack), 32'b100);
    process_ack("wr", ack, 1'b1);
    tick();

    // Dump read at bank 5 / 0x3F, RD_LAT=2: ack in cycle 4.
    post(1, 1'b0, 3'd5, 7'h3F, 8'h00);
    tick();
    check("rd mem_re", 32'(mem_re), 32'd1);
    check("rd bus", {22'd0, mem_bank, mem_addr}, {22'd0, 3'd5, 7'h3F});
    tick();
    check("rd c2 ack", 32'(ack), 32'd0);
    tick();
    check("rd c3 ack", 32'(ack), 32'd0);
    tick();
    check("rd c4 rdata", 32'(rdata), 32'h3C);
    process_ack("rd", ack, 1'b1);
    tick();

    // All three requesting continuously from reset.
    do_reset();
    post(0, 1'b1, 3'd0, 7'h01, 8'h11);
    post(1, 1'b0, 3'd5, 7'h3F, 8'h00);
    post(2, 1'b1, 3'd2, 7'h20, 8'h22);
    for (int n = 0; n < 6; n++) begin
      wait_ack("rr", a);
      check("rr order", 32'(a), 32'd1 << (n % 3));
      process_ack("rr", a, 1'b0);
    end
    req = '0; pending = '0;
    tick();

    // bulk_lock masks the host until released.
    bulk_lock = 1'b1;
    post(1, 1'b0, 3'd1, 7'h05, 8'h00);
    post(2, 1'b1, 3'd1, 7'h06, 8'h66);
    for (int n = 0; n < 3; n++) begin
      wait_ack("lock", a);
      check("lock only1", 32'(a), 32'b010);
      process_ack("lock", a, 1'b0);
    end
    bulk_lock = 1'b0;
    wait_ack("unlock", a);
    check("unlock host", 32'(a), 32'b100);
    process_ack("unlock", a, 1'b1);
    req = '0; pending = '0;
    tick();

    // Out-of-range host read.
    post(2, 1'b0, 3'd1, 7'd64, 8'h00);
    tick();
    check("err strobes", {30'd0, mem_we, mem_re}, 32'd0);
    tick();
    check("err ack", {28'd0, ack, ack_err}, {28'd0, 3'b100, 1'b1});
    process_ack("err", ack, 1'b1);
    tick();

    // Reset during RDWAIT aborts; pointer returns to 0.
    post(1, 1'b0, 3'd3, 7'h11, 8'h00);
    tick();
    check("abort mem_re", 32'(mem_re), 32'd1);
    tick();
    reset_reg_N = 1'b0;
    post(2, 1'b1, 3'd3, 7'h12, 8'h77);
    #1;
    check("abort outs", all_outs(), 32'd0);
    tick();
    check("abort held", all_outs(), 32'd0);
    reset_reg_N = 1'b1;
    mptr = 0;
    wait_ack("rearm", a);
    check("rearm first", 32'(a), 32'b010);
    process_ack("rearm", a, 1'b1);
    wait_ack("rearm2", a);
    check("rearm second", 32'(a), 32'b100);
    process_ack("rearm2", a, 1'b1);
    tick();

    // Randomized mixed traffic.
    for (int it = 0; it < 120; it++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(1, 7));
      bulk_lock = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          logic [6:0] ad;
          ad = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 63));
          post(i, (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), ad, 8'($urandom));
        end
      end
      while (pending != 3'b000) begin
        if (pending == 3'b100) bulk_lock = 1'b0;
        wait_ack("rand", a);
        if (a == 3'b000) begin
          req = '0; pending = '0;
        end else begin
          process_ack("rand", a, 1'b1);
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
